// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, alu_op codes,
// datapath mux selects and the main-control state numbering.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_ANDI  = 4'h2;
   localparam logic [3:0] OP_ORI   = 4'h3;
   localparam logic [3:0] OP_NORI  = 4'h4;
   localparam logic [3:0] OP_BEQ   = 4'h5;
   localparam logic [3:0] OP_BNE   = 4'h6;
   localparam logic [3:0] OP_SLTI  = 4'h7;
   localparam logic [3:0] OP_LW    = 4'h8;
   localparam logic [3:0] OP_SW    = 4'h9;
   localparam logic [3:0] OP_J     = 4'hA;

   // alu_op codes understood by alu_control
   localparam logic [2:0] ALU_OP_MEM    = 3'b000;
   localparam logic [2:0] ALU_OP_NORI   = 3'b001;
   localparam logic [2:0] ALU_OP_BRANCH = 3'b010;
   localparam logic [2:0] ALU_OP_ANDI   = 3'b011;
   localparam logic [2:0] ALU_OP_RTYPE  = 3'b100;
   localparam logic [2:0] ALU_OP_SLTI   = 3'b101;
   localparam logic [2:0] ALU_OP_ADDI   = 3'b110;
   localparam logic [2:0] ALU_OP_ORI    = 3'b111;

   localparam logic [1:0] ALUB_RT   = 2'b00;
   localparam logic [1:0] ALUB_TWO  = 2'b01;
   localparam logic [1:0] ALUB_SEXT = 2'b10;
   localparam logic [1:0] ALUB_ZEXT = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_ADDR     = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_WB_ALU   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_HALT_ILL = 4'd11
   } state_e;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
   } op_class_e;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
// opcode/zero/mem_ready flow into the controller; everything else flows out.
interface multicycle_main_control_if;
   logic [3:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [2:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       mem_read;
   logic       mem_write;
   logic       i_or_d;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       illegal_op;
   logic       mem_timeout;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, zero, mem_ready,
      output alu_op, alu_src_a, alu_src_b, ir_write, pc_write, pc_src,
             mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
             illegal_op, mem_timeout, state_dbg
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  alu_op, alu_src_a, alu_src_b, ir_write, pc_write, pc_src,
             mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
             illegal_op, mem_timeout, state_dbg
   );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier; shared by the DECODE dispatch and the
// EXEC_I operand/alu_op selection.
module opcode_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] opcode_i,
   output op_class_e  op_class_o,
   output logic [2:0] alu_op_o,
   output logic       zext_imm_o,
   output logic       is_rtype_o,
   output logic       illegal_o
);

   always_comb begin
      op_class_o = CLS_ILLEGAL;
      alu_op_o   = ALU_OP_MEM;
      zext_imm_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin op_class_o = CLS_R;      alu_op_o = ALU_OP_RTYPE;  end
         OP_ADDI:  begin op_class_o = CLS_I;      alu_op_o = ALU_OP_ADDI;   end
         OP_ANDI:  begin op_class_o = CLS_I;      alu_op_o = ALU_OP_ANDI;  zext_imm_o = 1'b1; end
         OP_ORI:   begin op_class_o = CLS_I;      alu_op_o = ALU_OP_ORI;   zext_imm_o = 1'b1; end
         OP_NORI:  begin op_class_o = CLS_I;      alu_op_o = ALU_OP_NORI;  zext_imm_o = 1'b1; end
         OP_SLTI:  begin op_class_o = CLS_I;      alu_op_o = ALU_OP_SLTI;   end
         OP_BEQ,
         OP_BNE:   begin op_class_o = CLS_BRANCH; alu_op_o = ALU_OP_BRANCH; end
         OP_LW,
         OP_SW:    begin op_class_o = CLS_MEM;    alu_op_o = ALU_OP_MEM;    end
         OP_J:     begin op_class_o = CLS_JUMP;   end
         default:  begin op_class_o = CLS_ILLEGAL; end
      endcase
   end

   assign is_rtype_o = (opcode_i == OP_RTYPE);
   assign illegal_o  = (op_class_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing
// with a bounded memory wait and a sticky illegal-opcode halt.
module multicycle_main_control
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input logic                        clk,
   input logic                        rst,
   multicycle_main_control_if.master  bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               illegal_q, illegal_d;
   logic               at_limit;

   op_class_e          dec_class;
   logic [2:0]         dec_alu_op;
   logic               dec_zext, dec_is_rtype, dec_illegal;

   opcode_decode u_decode (
      .opcode_i   (bus.opcode),
      .op_class_o (dec_class),
      .alu_op_o   (dec_alu_op),
      .zext_imm_o (dec_zext),
      .is_rtype_o (dec_is_rtype),
      .illegal_o  (dec_illegal)
   );

   assign at_limit       = (cnt_q == CNT_W'(MEM_TIMEOUT));
   assign bus.illegal_op = illegal_q;
   assign bus.state_dbg  = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Outputs are forced idle while rst is high so an abandoned instruction
   // cannot write anything in the reset cycle.
   always_comb begin
      state_d         = state_q;
      cnt_d           = '0;
      illegal_d       = illegal_q;
      bus.alu_op      = ALU_OP_MEM;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = ALUB_RT;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.pc_src      = PC_SRC_ALU;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.i_or_d      = 1'b0;
      bus.reg_write   = 1'b0;
      bus.reg_dst     = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.mem_timeout = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               bus.alu_src_b = ALUB_TWO;
               if (bus.mem_ready) begin
                  bus.mem_read = 1'b1;
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = ST_DECODE;
               end else if (at_limit) begin
                  bus.mem_timeout = 1'b1;
               end else begin
                  bus.mem_read = 1'b1;
                  cnt_d        = cnt_q + CNT_W'(1);
               end
            end
            ST_DECODE: begin
               bus.alu_src_b = ALUB_SEXT;
               if (dec_illegal) begin
                  state_d   = ST_HALT_ILL;
                  illegal_d = 1'b1;
               end else begin
                  case (dec_class)
                     CLS_R:      state_d = ST_EXEC_R;
                     CLS_I:      state_d = ST_EXEC_I;
                     CLS_MEM:    state_d = ST_ADDR;
                     CLS_BRANCH: state_d = ST_BRANCH;
                     CLS_JUMP:   state_d = ST_JUMP;
                     default:    state_d = ST_HALT_ILL;
                  endcase
               end
            end
            ST_EXEC_R: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = ALU_OP_RTYPE;
               state_d       = ST_WB_ALU;
            end
            ST_EXEC_I: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = dec_zext ? ALUB_ZEXT : ALUB_SEXT;
               bus.alu_op    = dec_alu_op;
               state_d       = ST_WB_ALU;
            end
            ST_ADDR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = ALUB_SEXT;
               state_d       = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD, ST_MEM_WR: begin
               if (bus.mem_ready || !at_limit) begin
                  bus.mem_read  = (state_q == ST_MEM_RD);
                  bus.mem_write = (state_q == ST_MEM_WR);
                  bus.i_or_d    = 1'b1;
               end
               if (bus.mem_ready)
                  state_d = (state_q == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
               else if (at_limit) begin
                  bus.mem_timeout = 1'b1;
                  state_d         = ST_FETCH;
               end else
                  cnt_d = cnt_q + CNT_W'(1);
            end
            ST_WB_ALU: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = dec_is_rtype;
               state_d       = ST_FETCH;
            end
            ST_WB_MEM: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
               state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = ALU_OP_BRANCH;
               if ((bus.opcode == OP_BEQ && bus.zero) || (bus.opcode == OP_BNE && !bus.zero)) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = PC_SRC_BRANCH;
               end
               state_d = ST_FETCH;
            end
            ST_JUMP: begin
               bus.pc_write = 1'b1;
               bus.pc_src   = PC_SRC_JUMP;
               state_d      = ST_FETCH;
            end
            ST_HALT_ILL: state_d = ST_HALT_ILL;
            default:     state_d = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: an instruction-level model expands each
// instruction into its expected per-cycle outputs and a compare process checks them.
module tb_multicycle_main_control;

   localparam int W = 22;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_main_control_if bus();

   multicycle_main_control #(.MEM_TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {state, alu_op, src_a, src_b, ir_w, pc_w, pc_src, mem_rd, mem_wr, i_or_d,
   //  reg_w, reg_dst, mem_to_reg, illegal, timeout}
   logic [W-1:0] dut_vec;
   assign dut_vec = {bus.state_dbg, bus.alu_op, bus.alu_src_a, bus.alu_src_b,
                     bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_read,
                     bus.mem_write, bus.i_or_d, bus.reg_write, bus.reg_dst,
                     bus.mem_to_reg, bus.illegal_op, bus.mem_timeout};

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_hist[$];
   logic [W-1:0] cmp_e;
   int           checks   = 0;
   int           failures = 0;
   logic         model_ill = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         cmp_e = exp_q.pop_front();
         check("cycle_outputs", 32'(dut_vec), 32'(cmp_e));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   function automatic logic [W-1:0] ov(input logic [3:0] st, input logic [2:0] aop,
                                       input logic a, input logic [1:0] b,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic mr, input logic mw, input logic iord,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic to);
      return {st, aop, a, b, irw, pcw, pcs, mr, mw, iord, rw, rd, m2r, model_ill, to};
   endfunction

   function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
      case (op)
         4'h1:    return 3'b110;
         4'h2:    return 3'b011;
         4'h3:    return 3'b111;
         4'h4:    return 3'b001;
         default: return 3'b101;
      endcase
   endfunction

   task automatic step(input logic [3:0] op, input logic z, input logic rdy, input logic [W-1:0] e);
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      exp_q.push_back(e);
      #2 obs_hist.push_back(dut_vec);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int ncyc);
      rst       = 1'b1;
      model_ill = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         #2 check("rst_no_enables", 32'({bus.reg_write, bus.mem_write, bus.mem_read,
                                        bus.pc_write, bus.ir_write}), 0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   // Expand one instruction into the cycle sequence the control must produce.
   task automatic run_instr(input logic [3:0] op, input logic z, input int fwait,
                            input int mwait, output int n);
      logic take;
      logic is_lw;
      obs_hist.delete();
      for (int i = 0; i < fwait; i++)
         step(op, z, 1'b0, ov(4'd0, 3'b000, 0, 2'b01, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0));
      step(op, z, 1'b1, ov(4'd0, 3'b000, 0, 2'b01, 1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0));
      step(op, z, 1'b1, ov(4'd1, 3'b000, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      case (op)
         4'h0: begin
            step(op, z, 1'b1, ov(4'd2, 3'b100, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            step(op, z, 1'b1, ov(4'd7, 3'b000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0));
         end
         4'h1, 4'h2, 4'h3, 4'h4, 4'h7: begin
            step(op, z, 1'b1, ov(4'd3, imm_alu_op(op), 1, (op inside {4'h2, 4'h3, 4'h4}) ? 2'b11 : 2'b10,
                                 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            step(op, z, 1'b1, ov(4'd7, 3'b000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0));
         end
         4'h8, 4'h9: begin
            is_lw = (op == 4'h8);
            step(op, z, 1'b1, ov(4'd4, 3'b000, 1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            for (int i = 0; i <= mwait; i++)
               step(op, z, (i == mwait), ov(is_lw ? 4'd5 : 4'd6, 3'b000, 0, 2'b00, 0, 0, 2'b00,
                                            is_lw, !is_lw, 1, 0, 0, 0, 0));
            if (is_lw)
               step(op, z, 1'b1, ov(4'd8, 3'b000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0));
         end
         4'h5, 4'h6: begin
            take = (op == 4'h5) ? z : !z;
            step(op, z, 1'b1, ov(4'd9, 3'b010, 1, 2'b00, 0, take, take ? 2'b01 : 2'b00,
                                 0, 0, 0, 0, 0, 0, 0));
         end
         4'hA: step(op, z, 1'b1, ov(4'd10, 3'b000, 0, 2'b00, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0));
         default: begin
            model_ill = 1'b1;
            for (int i = 0; i < 21; i++)
               step(op, z, 1'b1, ov(4'd11, 3'b000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
         end
      endcase
      n = obs_hist.size();
   endtask

   initial begin
      int           n;
      int           acc;
      int           idx;
      logic [W-1:0] v;
      logic [3:0]   iops [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
      logic [2:0]   iaop [5] = '{3'b110, 3'b011, 3'b111, 3'b001, 3'b101};
      logic [1:0]   ib   [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10};

      bus.opcode    = 4'h0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      do_reset(2);

      // R-type: 4 cycles, EXEC_R alu_op 100, WB_ALU writes rd
      run_instr(4'h0, 1'b0, 0, 0, n);
      check("rtype_len", n, 4);
      v = obs_hist[0];
      check("reset_fetch_state", 32'(v[21:18]), 0);
      check("reset_fetch_memrd", 32'(v[7]), 1);
      check("reset_fetch_srcb", 32'(v[13:12]), 32'b01);
      check("reset_fetch_aluop", 32'(v[17:15]), 0);
      v = obs_hist[2];
      check("rtype_aluop", 32'(v[17:15]), 32'b100);
      v = obs_hist[3];
      check("rtype_wb_regw_dst", 32'(v[4:3]), 32'b11);

      for (int k = 0; k < 5; k++) begin
         run_instr(iops[k], 1'b0, 0, 0, n);
         check("imm_len", n, 4);
         v = obs_hist[2];
         check("imm_aluop", 32'(v[17:15]), 32'(iaop[k]));
         check("imm_srcb", 32'(v[13:12]), 32'(ib[k]));
      end

      // lw with three wait cycles in MEM_RD
      run_instr(4'h8, 1'b0, 0, 3, n);
      check("lw_len", n, 8);
      acc = 0;
      for (int i = 3; i <= 6; i++) begin
         v = obs_hist[i];
         acc += int'(v[7]);
      end
      check("lw_memrd_cycles", acc, 4);
      v = obs_hist[7];
      check("lw_wb_mem_to_reg", 32'(v[2]), 1);

      run_instr(4'h9, 1'b0, 0, 0, n);
      check("sw_len", n, 4);
      acc = 0;
      foreach (obs_hist[i]) begin
         v = obs_hist[i];
         acc += int'(v[4]);
      end
      check("sw_no_regwrite", acc, 0);

      run_instr(4'h5, 1'b1, 0, 0, n);
      v = obs_hist[2];
      check("beq_taken", 32'(v[10:8]), 32'b101);
      check("beq_len", n, 3);
      run_instr(4'h5, 1'b0, 0, 0, n);
      v = obs_hist[2];
      check("beq_not_taken", 32'(v[10:8]), 0);
      run_instr(4'h6, 1'b0, 0, 0, n);
      v = obs_hist[2];
      check("bne_taken", 32'(v[10:8]), 32'b101);
      run_instr(4'h6, 1'b1, 0, 0, n);
      v = obs_hist[2];
      check("bne_not_taken", 32'(v[10:8]), 0);
      run_instr(4'hA, 1'b0, 0, 0, n);
      v = obs_hist[2];
      check("jump_pc", 32'(v[10:8]), 32'b110);
      check("jump_len", n, 3);

      // Fetch timeout: 15 waiting cycles, abort on the 16th
      obs_hist.delete();
      for (int i = 0; i < 15; i++)
         step(4'hA, 1'b0, 1'b0, ov(4'd0, 3'b000, 0, 2'b01, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0));
      step(4'hA, 1'b0, 1'b0, ov(4'd0, 3'b000, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
      idx = -1;
      foreach (obs_hist[i]) begin
         v = obs_hist[i];
         if (v[0] && idx < 0) idx = i;
      end
      check("timeout_cycle", idx, 15);
      run_instr(4'hA, 1'b0, 0, 0, n);
      check("after_timeout_len", n, 3);

      // Ready arriving exactly at the limit completes normally
      run_instr(4'h1, 1'b0, 15, 0, n);
      check("limit_ready_len", n, 19);
      acc = 0;
      foreach (obs_hist[i]) begin
         v = obs_hist[i];
         acc += int'(v[0]);
      end
      check("limit_ready_no_pulse", acc, 0);

      // Illegal opcode halts with a sticky flag
      run_instr(4'hC, 1'b0, 0, 0, n);
      check("illegal_len", n, 23);
      v = obs_hist[22];
      check("illegal_sticky", 32'(v[1]), 1);
      acc = 0;
      for (int i = 2; i < 23; i++) begin
         v = obs_hist[i];
         acc += int'(v[11:3] != 9'd0);
      end
      check("halt_no_enables", acc, 0);

      do_reset(1);
      // Start a lw, then reset while waiting in MEM_RD
      obs_hist.delete();
      step(4'h8, 1'b0, 1'b1, ov(4'd0, 3'b000, 0, 2'b01, 1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0));
      step(4'h8, 1'b0, 1'b1, ov(4'd1, 3'b000, 0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      step(4'h8, 1'b0, 1'b1, ov(4'd4, 3'b000, 1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      step(4'h8, 1'b0, 1'b0, ov(4'd5, 3'b000, 0, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0));
      v = obs_hist[0];
      check("illegal_cleared_by_rst", 32'(v[1]), 0);
      do_reset(1);
      run_instr(4'h0, 1'b0, 0, 0, n);
      v = obs_hist[0];
      check("mid_lw_rst_fetch", 32'(v[21:18]), 0);
      check("mid_lw_rst_len", n, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
